dw_conv_tm: RTL

DW_CONV_TM -- requirements
Module: dw_conv_tm

---
 rtl/dw_conv_pkg.sv | 43 ++++
 rtl/dw_conv_tm_mac_lane.sv | 32 +++
 rtl/dw_conv_tm.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dw_conv_pkg.sv
// Shared constants, FSM state type and requantisation helper for
// the depthwise 3x3 convolution layer blocks.
package dw_conv_pkg;

    localparam int DEF_CH    = 8;
    localparam int DEF_LANES = 2;
    localparam int DEF_AW    = 16;
    localparam int DEF_WW    = 8;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_SHIFT = 7;
    localparam int DEF_CLIP  = 6;

    localparam int TAPS  = 9;
    // Register file slots per channel: 9 weights then 1 bias.
    localparam int SLOTS = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    // Negative accumulators map to 0; otherwise arithmetic right shift
    // and saturate at clip. Caller sign-extends acc and truncates result.
    function automatic logic signed [63:0] relu_clip(
        input logic signed [63:0] acc,
        input int                 shift,
        input int                 clip
    );
        logic signed [63:0] q;
        logic signed [63:0] lim;
        lim = 64'(clip);
        q   = acc >>> shift;
        if (acc < 0) begin
            relu_clip = '0;
        end else if (q > lim) begin
            relu_clip = lim;
        end else begin
            relu_clip = q;
        end
    endfunction

endpackage

// File: rtl/dw_conv_tm_mac_lane.sv
// One combinational depthwise lane: 9-tap signed MAC plus bias,
// followed by ReLU/shift/clip. Ports: act (9 taps), wgt (9), bias, out.
module dw_mac_lane
    import dw_conv_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int WW    = DEF_WW,
    parameter int ACC_W = DEF_ACC_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int CLIP  = DEF_CLIP
) (
    input  logic [TAPS*AW-1:0] act,
    input  logic [TAPS*WW-1:0] wgt,
    input  logic [ACC_W-1:0]   bias,
    output logic [AW-1:0]      out
);

    logic signed [ACC_W-1:0] acc;

    // Operands are sign-extended to ACC_W before multiplying so the
    // whole sum wraps modulo 2^ACC_W.
    always_comb begin
        acc = $signed(bias);
        for (int t = 0; t < TAPS; t++) begin
            acc = acc
                + ACC_W'($signed(wgt[t*WW +: WW]))
                * ACC_W'($signed(act[t*AW +: AW]));
        end
        out = AW'(relu_clip(64'(acc), SHIFT, CLIP));
    end

endmodule

// File: rtl/dw_conv_tm.sv
// Time-multiplexed depthwise 3x3 conv: captures CH windows, computes
// LANES channels per cycle, holds the result until taken.
// Ports: clk/rstn, in_valid/in_ready/in_act, out_valid/out_ready/out_act,
// cfg_we/cfg_addr/cfg_wdata (weights t=0..8, bias t=9 per channel).
module dw_conv_tm
    import dw_conv_pkg::*;
#(
    parameter int CH    = DEF_CH,
    parameter int LANES = DEF_LANES,
    parameter int AW    = DEF_AW,
    parameter int WW    = DEF_WW,
    parameter int ACC_W = DEF_ACC_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int CLIP  = DEF_CLIP,
    localparam int ADW  = $clog2(CH*SLOTS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CH*TAPS*AW-1:0]  in_act,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH*AW-1:0]       out_act,
    input  logic                   cfg_we,
    input  logic [ADW-1:0]         cfg_addr,
    input  logic [ACC_W-1:0]       cfg_wdata
);

    localparam int NG = CH / LANES;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;

    if (CH % LANES != 0) begin : g_bad_lanes
        $error("dw_conv_tm: CH must be a multiple of LANES");
    end

    state_e                    state_q, state_d;
    logic [GW-1:0]             g_q, g_d;
    logic [CH*TAPS*AW-1:0]     act_q, act_d;
    logic [CH-1:0][TAPS*WW-1:0] w_q, w_d;
    logic [CH-1:0][ACC_W-1:0]  b_q, b_d;
    logic [CH*AW-1:0]          out_q, out_d;

    logic [LANES-1:0][TAPS*AW-1:0] lane_act;
    logic [LANES-1:0][TAPS*WW-1:0] lane_w;
    logic [LANES-1:0][ACC_W-1:0]   lane_b;
    logic [LANES-1:0][AW-1:0]      lane_out;

    // Route the current group's channels to the lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_act[l] = act_q[(int'(g_q)*LANES + l)*TAPS*AW +: TAPS*AW];
            lane_w[l]   = w_q[int'(g_q)*LANES + l];
            lane_b[l]   = b_q[int'(g_q)*LANES + l];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dw_mac_lane #(
            .AW    (AW),
            .WW    (WW),
            .ACC_W (ACC_W),
            .SHIFT (SHIFT),
            .CLIP  (CLIP)
        ) u_lane (
            .act  (lane_act[l]),
            .wgt  (lane_w[l]),
            .bias (lane_b[l]),
            .out  (lane_out[l])
        );
    end

    // Register file write port, open only while idle.
    always_comb begin
        int cidx;
        int tidx;
        w_d  = w_q;
        b_d  = b_q;
        cidx = int'(cfg_addr) / SLOTS;
        tidx = int'(cfg_addr) % SLOTS;
        if (cfg_we && (state_q == ST_IDLE)
            && (int'(cfg_addr) < CH*SLOTS)) begin
            if (tidx == TAPS) begin
                b_d[cidx] = cfg_wdata;
            end else begin
                w_d[cidx][tidx*WW +: WW] = cfg_wdata[WW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        act_d   = act_q;
        out_d   = out_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    act_d   = in_act;
                    g_d     = '0;
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                for (int l = 0; l < LANES; l++) begin
                    out_d[(int'(g_q)*LANES + l)*AW +: AW] = lane_out[l];
                end
                if (int'(g_q) == NG-1) begin
                    g_d     = '0;
                    state_d = ST_HOLD;
                end else begin
                    g_d = g_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            act_q   <= '0;
            w_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            act_q   <= act_d;
            w_q     <= w_d;
            b_q     <= b_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);
    assign out_act   = out_q;

endmodule
